// File: rtl/periph_trig_pkg.sv
// Shared types and constants for the peripheral trigger agent and the trigger matrix.
package periph_trig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        OIDLE  = 2'd0,
        ODELAY = 2'd1,
        OACK   = 2'd2
    } out_state_t;

    localparam logic [1:0] HW_TRIG_TYPE = 2'b10;

endpackage

// File: rtl/trig_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset for single-bit handshake inputs.
module trig_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/periph_trig_agent.sv
// Peripheral trigger endpoint: event pulses -> 4-phase trig_req/trig_ack, plus trigger-out responder.
// Define PERIPH_TRIG_SYNC_EN to pass trig_ack and trig_out_req through 2-flop synchronizers.
module periph_trig_agent
    import periph_trig_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int ACK_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             evt_pulse,
    output logic             trig_req,
    input  logic             trig_ack,
    input  logic             trig_out_req,
    output logic             trig_out_ack,
    output logic             trig_out_evt,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf_err,
    output logic             proto_err,
    input  logic             clr_err
);

    localparam int               DLY_W    = (ACK_DLY > 1) ? $clog2(ACK_DLY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
    localparam logic [DLY_W-1:0] DLY_LOAD = (ACK_DLY > 0) ? DLY_W'(ACK_DLY - 1) : {DLY_W{1'b0}};

    logic ack_s;
    logic oreq_s;

`ifdef PERIPH_TRIG_SYNC_EN
    trig_sync2 u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d_i (trig_ack),
        .q_o (ack_s)
    );

    trig_sync2 u_sync_oreq (
        .clk (clk),
        .rst (rst),
        .d_i (trig_out_req),
        .q_o (oreq_s)
    );
`else
    assign ack_s  = trig_ack;
    assign oreq_s = trig_out_req;
`endif

    in_state_t        in_state_q;
    out_state_t       out_state_q;
    logic             trig_req_q;
    logic             trig_out_ack_q;
    logic             trig_out_evt_q;
    logic [DLY_W-1:0] dly_q;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic             ovf_err_q, ovf_err_d;
    logic             proto_err_q, proto_err_d;
    logic             inc_s;
    logic             dec_s;
    logic             ovf_set_s;
    logic             proto_set_s;

    // Pending-count and sticky-error next state; a set on the same edge as clr_err wins.
    always_comb begin
        inc_s       = evt_pulse;
        dec_s       = (in_state_q == REQ) && ack_s;
        pend_cnt_d  = pend_cnt_q;
        ovf_set_s   = 1'b0;
        proto_set_s = (out_state_q == ODELAY) && !oreq_s;
        case ({inc_s, dec_s})
            2'b10: begin
                if (pend_cnt_q == CNT_MAX) begin
                    ovf_set_s = 1'b1;
                end else begin
                    pend_cnt_d = pend_cnt_q + CNT_ONE;
                end
            end
            2'b01:   pend_cnt_d = pend_cnt_q - CNT_ONE;
            default: pend_cnt_d = pend_cnt_q;
        endcase

        if (ovf_set_s) begin
            ovf_err_d = 1'b1;
        end else if (clr_err) begin
            ovf_err_d = 1'b0;
        end else begin
            ovf_err_d = ovf_err_q;
        end

        if (proto_set_s) begin
            proto_err_d = 1'b1;
        end else if (clr_err) begin
            proto_err_d = 1'b0;
        end else begin
            proto_err_d = proto_err_q;
        end
    end

    // Counter and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt_q  <= {CNT_W{1'b0}};
            ovf_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pend_cnt_q  <= pend_cnt_d;
            ovf_err_q   <= ovf_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Trigger-in handshake FSM; enable only gates the start of a new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q <= IDLE;
            trig_req_q <= 1'b0;
        end else begin
            case (in_state_q)
                IDLE: begin
                    if (enable && (pend_cnt_q != {CNT_W{1'b0}})) begin
                        in_state_q <= REQ;
                        trig_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        in_state_q <= RELEASE;
                        trig_req_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        in_state_q <= IDLE;
                    end
                end
                default: begin
                    in_state_q <= IDLE;
                    trig_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Trigger-out responder FSM; a request withdrawn before the ack is a protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q    <= OIDLE;
            trig_out_ack_q <= 1'b0;
            trig_out_evt_q <= 1'b0;
            dly_q          <= {DLY_W{1'b0}};
        end else begin
            trig_out_evt_q <= 1'b0;
            case (out_state_q)
                OIDLE: begin
                    if (oreq_s) begin
                        trig_out_evt_q <= 1'b1;
                        if (ACK_DLY == 0) begin
                            out_state_q    <= OACK;
                            trig_out_ack_q <= 1'b1;
                        end else begin
                            out_state_q <= ODELAY;
                            dly_q       <= DLY_LOAD;
                        end
                    end
                end
                ODELAY: begin
                    if (!oreq_s) begin
                        out_state_q <= OIDLE;
                    end else if (dly_q == {DLY_W{1'b0}}) begin
                        out_state_q    <= OACK;
                        trig_out_ack_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q - DLY_ONE;
                    end
                end
                OACK: begin
                    if (!oreq_s) begin
                        out_state_q    <= OIDLE;
                        trig_out_ack_q <= 1'b0;
                    end
                end
                default: begin
                    out_state_q    <= OIDLE;
                    trig_out_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign trig_req     = trig_req_q;
    assign trig_out_ack = trig_out_ack_q;
    assign trig_out_evt = trig_out_evt_q;
    assign pend_cnt     = pend_cnt_q;
    assign ovf_err      = ovf_err_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_periph_trig_agent.sv
// Directed bench for periph_trig_agent: instance A uses ACK_DLY=2, instance B uses ACK_DLY=0.
module tb_periph_trig_agent;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       evt_pulse = 1'b0;
    logic       trig_ack = 1'b0;
    logic       trig_out_req = 1'b0;
    logic       trig_out_req0 = 1'b0;
    logic       clr_err = 1'b0;

    logic       trig_req, trig_out_ack, trig_out_evt, ovf_err, proto_err;
    logic [3:0] pend_cnt;
    logic       b_trig_req, b_trig_out_ack, b_trig_out_evt, b_ovf_err, b_proto_err;
    logic [3:0] b_pend_cnt;

    int n_checks = 0;
    int n_errors = 0;

    periph_trig_agent #(.CNT_W(4), .ACK_DLY(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .evt_pulse    (evt_pulse),
        .trig_req     (trig_req),
        .trig_ack     (trig_ack),
        .trig_out_req (trig_out_req),
        .trig_out_ack (trig_out_ack),
        .trig_out_evt (trig_out_evt),
        .pend_cnt     (pend_cnt),
        .ovf_err      (ovf_err),
        .proto_err    (proto_err),
        .clr_err      (clr_err)
    );

    periph_trig_agent #(.CNT_W(4), .ACK_DLY(0)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .enable       (1'b0),
        .evt_pulse    (1'b0),
        .trig_req     (b_trig_req),
        .trig_ack     (1'b0),
        .trig_out_req (trig_out_req0),
        .trig_out_ack (b_trig_out_ack),
        .trig_out_evt (b_trig_out_evt),
        .pend_cnt     (b_pend_cnt),
        .ovf_err      (b_ovf_err),
        .proto_err    (b_proto_err),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("rst_req", trig_req, 32'd0);
        chk("rst_cnt", pend_cnt, 32'd0);
        chk("rst_ovf", ovf_err, 32'd0);
        chk("rst_proto", proto_err, 32'd0);
        chk("rst_oack", trig_out_ack, 32'd0);
        chk("rst_oevt", trig_out_evt, 32'd0);
        rst = 1'b0; enable = 1'b1;
        tick;

        // Single event, ack returned after three request cycles
        evt_pulse = 1'b1; tick;
        chk("t1_cnt1", pend_cnt, 32'd1);
        chk("t1_req_lat", trig_req, 32'd0);
        evt_pulse = 1'b0; tick;
        chk("t1_req_rise", trig_req, 32'd1);
        chk("t1_cnt_hold", pend_cnt, 32'd1);
        tick; chk("t1_req_hold1", trig_req, 32'd1);
        tick; chk("t1_req_hold2", trig_req, 32'd1);
        trig_ack = 1'b1; tick;
        chk("t1_req_fall", trig_req, 32'd0);
        chk("t1_cnt0", pend_cnt, 32'd0);
        tick; chk("t1_release", trig_req, 32'd0);
        trig_ack = 1'b0; tick; tick;
        chk("t1_idle", trig_req, 32'd0);
        chk("t1_ovf", ovf_err, 32'd0);
        chk("t1_proto", proto_err, 32'd0);

        // Enable gating, then event coinciding with ack at count 3
        enable = 1'b0; evt_pulse = 1'b1;
        tick; tick; tick;
        evt_pulse = 1'b0;
        chk("t3_cnt3", pend_cnt, 32'd3);
        chk("t3_gated", trig_req, 32'd0);
        enable = 1'b1; tick;
        chk("t3_req", trig_req, 32'd1);
        trig_ack = 1'b1; evt_pulse = 1'b1; tick;
        evt_pulse = 1'b0;
        chk("t3_cnt_same", pend_cnt, 32'd3);
        chk("t3_req_drop", trig_req, 32'd0);
        tick; chk("t3_rel_cnt", pend_cnt, 32'd3);
        trig_ack = 1'b0; tick;
        chk("t3_idle_gap", trig_req, 32'd0);
        tick; chk("t3_new_req", trig_req, 32'd1);
        enable = 1'b0; tick;
        chk("t3_no_abort", trig_req, 32'd1);
        enable = 1'b1; trig_ack = 1'b1; tick;
        chk("t3_cnt2", pend_cnt, 32'd2);
        trig_ack = 1'b0; tick;
        evt_pulse = 1'b1; tick; tick; tick;
        evt_pulse = 1'b0;
        chk("t6_cnt5", pend_cnt, 32'd5);
        chk("t6_in_req", trig_req, 32'd1);

        // Asynchronous reset mid-request
        rst = 1'b1; #1;
        chk("t6_async_req", trig_req, 32'd0);
        chk("t6_async_cnt", pend_cnt, 32'd0);
        tick; tick;
        rst = 1'b0;
        tick; tick; tick;
        chk("t6_post_req", trig_req, 32'd0);
        chk("t6_post_cnt", pend_cnt, 32'd0);

        // Saturation and sticky overflow
        evt_pulse = 1'b1;
        repeat (15) tick;
        chk("t2_cnt15", pend_cnt, 32'd15);
        chk("t2_no_ovf", ovf_err, 32'd0);
        tick;
        chk("t2_sat", pend_cnt, 32'd15);
        chk("t2_ovf", ovf_err, 32'd1);
        chk("t2_req", trig_req, 32'd1);
        evt_pulse = 1'b0; clr_err = 1'b1; tick;
        chk("t2_clr", ovf_err, 32'd0);
        chk("t2_cnt_kept", pend_cnt, 32'd15);
        evt_pulse = 1'b1; tick;
        chk("t2_set_wins", ovf_err, 32'd1);
        evt_pulse = 1'b0; tick;
        chk("t2_clr2", ovf_err, 32'd0);
        clr_err = 1'b0;
        trig_ack = 1'b1; evt_pulse = 1'b1; tick;
        evt_pulse = 1'b0;
        chk("t2_inc_dec_sat", pend_cnt, 32'd15);
        chk("t2_inc_dec_ovf", ovf_err, 32'd0);
        trig_ack = 1'b0;

        // Trigger-out: A with 2-cycle delay, B with zero delay
        trig_out_req = 1'b1; trig_out_req0 = 1'b1; tick;
        chk("t4_evt", trig_out_evt, 32'd1);
        chk("t4_ack0", trig_out_ack, 32'd0);
        chk("t4b_evt", b_trig_out_evt, 32'd1);
        chk("t4b_ack", b_trig_out_ack, 32'd1);
        tick;
        chk("t4_evt_once", trig_out_evt, 32'd0);
        chk("t4_ack1", trig_out_ack, 32'd0);
        chk("t4b_evt_once", b_trig_out_evt, 32'd0);
        tick;
        chk("t4_ack_rise", trig_out_ack, 32'd1);
        tick;
        chk("t4_ack_hold", trig_out_ack, 32'd1);
        chk("t4_evt_quiet", trig_out_evt, 32'd0);
        trig_out_req = 1'b0; trig_out_req0 = 1'b0; tick;
        chk("t4_ack_fall", trig_out_ack, 32'd0);
        chk("t4b_ack_fall", b_trig_out_ack, 32'd0);
        chk("t4_proto", proto_err, 32'd0);
        chk("t4b_proto", b_proto_err, 32'd0);

        // Request withdrawn during the delay
        trig_out_req = 1'b1; tick;
        chk("t5_evt", trig_out_evt, 32'd1);
        trig_out_req = 1'b0; tick;
        chk("t5_no_ack", trig_out_ack, 32'd0);
        chk("t5_proto", proto_err, 32'd1);
        tick;
        chk("t5_no_ack2", trig_out_ack, 32'd0);
        chk("t5_proto_sticky", proto_err, 32'd1);
        trig_out_req = 1'b1; tick;
        chk("t5_reaccept", trig_out_evt, 32'd1);
        tick; tick;
        chk("t5_ack", trig_out_ack, 32'd1);
        trig_out_req = 1'b0; tick;
        chk("t5_ack_fall", trig_out_ack, 32'd0);
        clr_err = 1'b1; tick;
        clr_err = 1'b0;
        chk("t5_clr", proto_err, 32'd0);

        // Instance B trigger-in side stayed quiet
        chk("b_req", b_trig_req, 32'd0);
        chk("b_cnt", b_pend_cnt, 32'd0);
        chk("b_ovf", b_ovf_err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/periph_trig_agent.md
Name: periph_trig_agent

Overview:
Peripheral-side endpoint of the DMA hardware trigger interface. It converts peripheral event pulses into 4-phase trig_req/trig_ack handshakes toward the trigger matrix. It also acts as responder for DMA trigger-out requests (trig_out_req/trig_out_ack). One instance sits on each peripheral trigger port (trig0, trig1).

Parameters:
CNT_W, 4, width of pending-event counter; maximum pending count is 2^CNT_W-1.
ACK_DLY, 2, cycles from trig_out_req acceptance to trig_out_ack assertion (0 is legal).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
enable  in  1  permits new trigger-in handshakes to start
evt_pulse  in  1  single-cycle peripheral request event
trig_req  out  1  trigger request toward the matrix
trig_ack  in  1  acknowledge from the matrix
trig_out_req  in  1  trigger-out request from the matrix
trig_out_ack  out  1  trigger-out acknowledge toward the matrix
trig_out_evt  out  1  one-cycle pulse to the peripheral when a trigger-out is accepted
pend_cnt  out  CNT_W  number of events not yet acknowledged
ovf_err  out  1  sticky: event lost because pend_cnt was saturated
proto_err  out  1  sticky: trig_out_req dropped before trig_out_ack
clr_err  in  1  clears both sticky error flags

Behaviour:
Reset: all outputs 0; pend_cnt 0; both FSMs idle.

Pending counter:
- evt_pulse high at edge k increments pend_cnt after edge k.
- An acknowledge consumed on the same edge decrements it; simultaneous increment and decrement leaves the count unchanged.
- Saturation: if pend_cnt is at max, evt_pulse arrives and no decrement occurs, the count holds and ovf_err is set.
- Error flags: clr_err clears them; if set and clear occur on the same edge, set wins.

Trigger-in FSM (states IDLE, REQ, RELEASE), trig_req registered:
- IDLE: moves to REQ when enable=1 and pend_cnt!=0. trig_req rises on that edge, so latency from evt_pulse to trig_req is 2 edges.
- REQ: trig_req held high. When trig_ack=1 is sampled: pend_cnt decrements, trig_req falls, move to RELEASE.
- RELEASE: trig_req stays low until trig_ack=0 is sampled, then move to IDLE. Back-to-back requests need at least 1 idle cycle.
- enable going low never aborts a handshake in progress; it only blocks the IDLE->REQ transition. pend_cnt is retained.

Trigger-out FSM (states OIDLE, ODELAY, OACK), trig_out_ack registered:
- OIDLE: on trig_out_req=1, trig_out_evt pulses for 1 cycle. Load the delay counter with ACK_DLY-1 and go to ODELAY; go directly to OACK if ACK_DLY=0.
- ODELAY: counts down; at 0, go to OACK with trig_out_ack=1.
- OACK: trig_out_ack held until trig_out_req=0 is sampled; ack falls on that edge and the FSM returns to OIDLE.
- If trig_out_req drops during ODELAY: return to OIDLE with no ack, and set proto_err.

Reset mid-handshake: all state is cleared immediately and pending events are discarded. Both trigger-in and trigger-out handshakes restart from idle.

Optional Feature:
PERIPH_TRIG_SYNC_EN:
- Defined: trig_ack and trig_out_req each pass through a 2-flop synchronizer before use, for peripherals on an asynchronous clock. Every handshake response is 2 cycles later.
- Undefined: inputs are sampled directly, with the timing given above.

Decomposition:
Package periph_trig_pkg holds:
- in_state_t {IDLE, REQ, RELEASE}
- out_state_t {OIDLE, ODELAY, OACK}
- localparam HW_TRIG_TYPE = 2'b10, shared with the trigger matrix

One sub-module, trig_sync2 (2-flop synchronizer with async reset), instantiated only under PERIPH_TRIG_SYNC_EN.

Test Plan:
1. evt_pulse at cycle 5, enable=1, trig_ack returned 3 cycles after trig_req -> trig_req high cycles 7-9, pend_cnt 1 then 0, trig_req low after ack, no errors.
2. 16 evt_pulses with trig_ack held low, CNT_W=4 -> pend_cnt saturates at 15, ovf_err=1. Pulse clr_err -> ovf_err=0, pend_cnt still 15.
3. evt_pulse on the same edge trig_ack is sampled with pend_cnt=3 -> pend_cnt stays 3, trig_req drops, new request after RELEASE.
4. trig_out_req held high, ACK_DLY=2 -> trig_out_evt pulses once, trig_out_ack high 2 cycles later, falls 1 cycle after trig_out_req drops. With ACK_DLY=0, ack follows on the next edge.
5. trig_out_req dropped during ODELAY -> no trig_out_ack, proto_err=1, FSM back in OIDLE.
6. rst asserted during REQ with pend_cnt=5 -> trig_req=0 and pend_cnt=0 immediately. After release, the FSM is idle and no request is issued without new events.
